// File: rtl/icache_pf_pkg.sv
// Shared types for the I-cache refill arbiter: control FSM states and the
// outstanding-refill slot record.
package icache_pf_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } arb_state_e;

  // Slot fields are sized for the widest supported configuration; narrower
  // instances zero-extend into them.
  localparam int SLOT_LINE_W = 64;
  localparam int SLOT_ID_W   = 32;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_LINE_W-1:0] line;
    logic [SLOT_ID_W-1:0]   id;
  } slot_t;

endpackage

// File: rtl/refill_outstanding_table.sv
// Outstanding refill slots: lowest-free allocate, lowest-match retire by ID,
// and prefetch line compare against slots and the concurrent miss.
module refill_outstanding_table
  import icache_pf_pkg::*;
#(
  parameter int ID_WIDTH        = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LINE_W          = 28
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 alloc_i,
  input  logic [LINE_W-1:0]                    alloc_line_i,
  input  logic [ID_WIDTH-1:0]                  alloc_id_i,
  input  logic                                 retire_i,
  input  logic [ID_WIDTH-1:0]                  retire_id_i,
  input  logic [LINE_W-1:0]                    pf_line_i,
  input  logic                                 miss_vld_i,
  input  logic [LINE_W-1:0]                    miss_line_i,
  output logic                                 pf_hit_o,
  output logic                                 full_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] count_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING+1);

  slot_t [MAX_OUTSTANDING-1:0] slot_q, slot_d;
  logic  [CW-1:0]              count_q, count_d;
  logic                        placed, found;

  // Allocation scans slot_q, so a slot freed this cycle is not reusable yet.
  always_comb begin
    slot_d  = slot_q;
    placed  = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!found && retire_i && slot_q[i].valid &&
          slot_q[i].id == SLOT_ID_W'(retire_id_i)) begin
        slot_d[i].valid = 1'b0;
        found = 1'b1;
      end
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!placed && alloc_i && !slot_q[i].valid) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].line  = SLOT_LINE_W'(alloc_line_i);
        slot_d[i].id    = SLOT_ID_W'(alloc_id_i);
        placed = 1'b1;
      end
    end
    count_d = count_q + CW'(placed) - CW'(found);
  end

  always_comb begin
    pf_hit_o = miss_vld_i && (miss_line_i == pf_line_i);
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (slot_q[i].valid && slot_q[i].line == SLOT_LINE_W'(pf_line_i)) begin
        pf_hit_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == CW'(MAX_OUTSTANDING));
  assign count_o = count_q;

endmodule

// File: rtl/icache_refill_arbiter.sv
// Arbitrates demand misses and prefetches onto one L2 refill port with
// alternating priority, prefetch squash, and a flush/drain FSM.
module icache_refill_arbiter
  import icache_pf_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LINE_OFFSET     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 miss_req_i,
  input  logic [ADDR_WIDTH-1:0]                miss_add_i,
  input  logic [ID_WIDTH-1:0]                  miss_ID_i,
  output logic                                 miss_gnt_o,
  input  logic                                 pf_req_i,
  input  logic [ADDR_WIDTH-1:0]                pf_add_i,
  input  logic [ID_WIDTH-1:0]                  pf_ID_i,
  output logic                                 pf_gnt_o,
  input  logic                                 pf_enable_i,
  input  logic                                 flush_i,
  output logic                                 refill_req_o,
  output logic [ADDR_WIDTH-1:0]                refill_add_o,
  output logic [ID_WIDTH-1:0]                  refill_ID_o,
  input  logic                                 refill_gnt_i,
  input  logic                                 refill_r_valid_i,
  input  logic [ID_WIDTH-1:0]                  refill_r_ID_i,
  output logic                                 pf_drop_o,
  output logic                                 flush_ack_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET;

  arb_state_e state_q;
  logic       arb_q;
  logic       run, full, pf_hit, pf_eff, pf_cand, squash, sel_pf, issue;

  refill_outstanding_table #(
    .ID_WIDTH       (ID_WIDTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .LINE_W         (LINE_W)
  ) u_tbl (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_i     (issue),
    .alloc_line_i(refill_add_o[ADDR_WIDTH-1:LINE_OFFSET]),
    .alloc_id_i  (refill_ID_o),
    .retire_i    (refill_r_valid_i),
    .retire_id_i (refill_r_ID_i),
    .pf_line_i   (pf_add_i[ADDR_WIDTH-1:LINE_OFFSET]),
    .miss_vld_i  (miss_req_i),
    .miss_line_i (miss_add_i[ADDR_WIDTH-1:LINE_OFFSET]),
    .pf_hit_o    (pf_hit),
    .full_o      (full),
    .count_o     (outstanding_o)
  );

  assign run     = (state_q == RUN);
  assign pf_eff  = pf_req_i & pf_enable_i;
  // A squashed prefetch is acknowledged even when full, but never during drain.
  assign squash  = run & pf_eff & pf_hit;
  assign pf_cand = pf_eff & ~pf_hit;
  assign sel_pf  = pf_cand & (~miss_req_i | arb_q);

  assign refill_req_o = run & ~full & (miss_req_i | pf_cand);
  assign refill_add_o = !refill_req_o ? '0 : (sel_pf ? pf_add_i : miss_add_i);
  assign refill_ID_o  = !refill_req_o ? '0 : (sel_pf ? pf_ID_i : miss_ID_i);
  assign issue        = refill_req_o & refill_gnt_i;

  assign miss_gnt_o  = issue & ~sel_pf;
  assign pf_gnt_o    = squash | (issue & sel_pf);
  assign pf_drop_o   = squash;
  assign flush_ack_o = ~run & (outstanding_o == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      arb_q   <= 1'b0;
    end else begin
      if (issue) arb_q <= ~sel_pf;
      case (state_q)
        RUN:     if (flush_i) state_q <= DRAIN;
        DRAIN:   if (outstanding_o == '0) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Directed bench for icache_refill_arbiter with hand-computed expectations.
module tb_icache_refill_arbiter;
  import icache_pf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_req_i, pf_req_i, pf_enable_i, flush_i;
  logic [31:0] miss_add_i, pf_add_i;
  logic [15:0] miss_ID_i, pf_ID_i;
  logic        miss_gnt_o, pf_gnt_o, refill_req_o, refill_gnt_i, refill_r_valid_i;
  logic [31:0] refill_add_o;
  logic [15:0] refill_ID_o, refill_r_ID_i;
  logic        pf_drop_o, flush_ack_o;
  logic [2:0]  outstanding_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  icache_refill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req_i(miss_req_i), .miss_add_i(miss_add_i), .miss_ID_i(miss_ID_i),
    .miss_gnt_o(miss_gnt_o),
    .pf_req_i(pf_req_i), .pf_add_i(pf_add_i), .pf_ID_i(pf_ID_i), .pf_gnt_o(pf_gnt_o),
    .pf_enable_i(pf_enable_i), .flush_i(flush_i),
    .refill_req_o(refill_req_o), .refill_add_o(refill_add_o), .refill_ID_o(refill_ID_o),
    .refill_gnt_i(refill_gnt_i), .refill_r_valid_i(refill_r_valid_i),
    .refill_r_ID_i(refill_r_ID_i), .pf_drop_o(pf_drop_o), .flush_ack_o(flush_ack_o),
    .outstanding_o(outstanding_o)
  );

  task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  task settle();
    #2;
  endtask

  task idle();
    miss_req_i = 0; miss_add_i = '0; miss_ID_i = '0;
    pf_req_i = 0; pf_add_i = '0; pf_ID_i = '0; pf_enable_i = 1;
    flush_i = 0; refill_gnt_i = 1; refill_r_valid_i = 0; refill_r_ID_i = '0;
  endtask

  task miss(input logic [31:0] a, input logic [15:0] id);
    miss_req_i = 1; miss_add_i = a; miss_ID_i = id;
  endtask

  task pf(input logic [31:0] a, input logic [15:0] id);
    pf_req_i = 1; pf_add_i = a; pf_ID_i = id;
  endtask

  task resp(input logic [15:0] id);
    refill_r_valid_i = 1; refill_r_ID_i = id;
    tick();
    refill_r_valid_i = 0;
  endtask

  task chk_all_zero(input string tag);
    chk({tag, ".req"}, refill_req_o, 0);
    chk({tag, ".mgnt"}, miss_gnt_o, 0);
    chk({tag, ".pgnt"}, pf_gnt_o, 0);
    chk({tag, ".drop"}, pf_drop_o, 0);
    chk({tag, ".ack"}, flush_ack_o, 0);
    chk({tag, ".cnt"}, outstanding_o, 0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    chk_all_zero("reset");
    #1 rst_n = 1;
    tick();

    // Alternating priority: ch0, then ch1, then ch0 again
    miss(32'h2000, 16'h11); pf(32'h3000, 16'h22);
    settle();
    chk("arb1.req", refill_req_o, 1);
    chk("arb1.add", refill_add_o, 32'h2000);
    chk("arb1.id", refill_ID_o, 16'h11);
    chk("arb1.mgnt", miss_gnt_o, 1);
    chk("arb1.pgnt", pf_gnt_o, 0);
    tick();
    settle();
    chk("arb2.add", refill_add_o, 32'h3000);
    chk("arb2.id", refill_ID_o, 16'h22);
    chk("arb2.pgnt", pf_gnt_o, 1);
    chk("arb2.mgnt", miss_gnt_o, 0);
    tick();
    miss(32'h2400, 16'h33); pf(32'h3400, 16'h44); refill_gnt_i = 0;
    settle();
    chk("arb3.add", refill_add_o, 32'h2400);
    chk("arb3.mgnt", miss_gnt_o, 0);
    chk("arb3.cnt", outstanding_o, 2);
    idle();
    pf(32'h5000, 16'h55); pf_enable_i = 0;
    settle();
    chk("pfmask.req", refill_req_o, 0);
    chk("pfmask.pgnt", pf_gnt_o, 0);
    idle();
    resp(16'h11);
    resp(16'h22);
    settle();
    chk("arb.clear", outstanding_o, 0);

    // Fill all four slots, stall the fifth, free ID 2 and reuse slot 1
    for (int i = 1; i <= 4; i++) begin
      miss(32'(i) << 8, 16'(i));
      settle();
      chk("fill.mgnt", miss_gnt_o, 1);
      tick();
    end
    miss(32'h500, 16'h5);
    settle();
    chk("full.req", refill_req_o, 0);
    chk("full.mgnt", miss_gnt_o, 0);
    chk("full.cnt", outstanding_o, 4);
    pf(32'h204, 16'h66);
    settle();
    chk("full.sq.pgnt", pf_gnt_o, 1);
    chk("full.sq.drop", pf_drop_o, 1);
    pf_req_i = 0;
    refill_r_valid_i = 1; refill_r_ID_i = 16'h2;
    settle();
    chk("full.resp.req", refill_req_o, 0);
    tick();
    refill_r_valid_i = 0;
    settle();
    chk("reuse.req", refill_req_o, 1);
    chk("reuse.mgnt", miss_gnt_o, 1);
    chk("reuse.cnt", outstanding_o, 3);
    tick();
    idle();
    settle();
    chk("reuse.cnt4", outstanding_o, 4);
    chk("reuse.slot1", dut.u_tbl.slot_q[1].id, 32'h5);
    resp(16'h1); resp(16'h3); resp(16'h4); resp(16'h5);
    settle();
    chk("fill.clear", outstanding_o, 0);

    // Prefetch squash against an outstanding line and the concurrent miss
    miss(32'h1000, 16'hA);
    tick();
    idle();
    pf(32'h100C, 16'hB);
    settle();
    chk("sq.pgnt", pf_gnt_o, 1);
    chk("sq.drop", pf_drop_o, 1);
    chk("sq.req", refill_req_o, 0);
    tick();
    pf(32'h1010, 16'hB);
    settle();
    chk("fwd.req", refill_req_o, 1);
    chk("fwd.add", refill_add_o, 32'h1010);
    chk("fwd.drop", pf_drop_o, 0);
    chk("fwd.cnt", outstanding_o, 1);
    tick();
    idle();
    miss(32'h2000, 16'hC); pf(32'h2008, 16'hE);
    settle();
    chk("sqm.drop", pf_drop_o, 1);
    chk("sqm.mgnt", miss_gnt_o, 1);
    chk("sqm.add", refill_add_o, 32'h2000);
    tick();
    idle();

    // Same-cycle issue and retire at count 3, then an unmatched response
    miss(32'h3000, 16'hD);
    refill_r_valid_i = 1; refill_r_ID_i = 16'hA;
    settle();
    chk("swap.mgnt", miss_gnt_o, 1);
    tick();
    idle();
    settle();
    chk("swap.cnt", outstanding_o, 3);
    chk("swap.slot3", dut.u_tbl.slot_q[3].id, 32'hD);
    chk("swap.slot0", dut.u_tbl.slot_q[0].valid, 0);
    resp(16'h7FFF);
    settle();
    chk("unmatched.cnt", outstanding_o, 3);

    // Asynchronous reset with three refills in flight
    miss(32'h7000, 16'hF);
    settle();
    chk("prerst.req", refill_req_o, 1);
    idle();
    rst_n = 0;
    #1;
    chk_all_zero("midrst");
    #1 rst_n = 1;
    tick();
    resp(16'hB);
    settle();
    chk("postrst.cnt", outstanding_o, 0);

    // Flush: drain two refills, ack once, re-enter drain while flush is held
    miss(32'h4000, 16'h1);
    tick();
    miss(32'h5000, 16'h2);
    tick();
    idle();
    flush_i = 1;
    settle();
    chk("fl.cnt", outstanding_o, 2);
    chk("fl.ack0", flush_ack_o, 0);
    tick();
    miss(32'h6000, 16'h3); pf(32'h4000, 16'h4);
    settle();
    chk("fl.state", dut.state_q, DRAIN);
    chk("fl.req", refill_req_o, 0);
    chk("fl.mgnt", miss_gnt_o, 0);
    chk("fl.pgnt", pf_gnt_o, 0);
    chk("fl.drop", pf_drop_o, 0);
    miss_req_i = 0; pf_req_i = 0;
    resp(16'h1);
    settle();
    chk("fl.ack1", flush_ack_o, 0);
    resp(16'h2);
    settle();
    chk("fl.cnt0", outstanding_o, 0);
    chk("fl.ack", flush_ack_o, 1);
    tick();
    settle();
    chk("fl.run", dut.state_q, RUN);
    chk("fl.ackpulse", flush_ack_o, 0);
    tick();
    settle();
    chk("fl.reenter", dut.state_q, DRAIN);
    chk("fl.reack", flush_ack_o, 1);
    flush_i = 0;
    tick();
    settle();
    chk("fl.final", dut.state_q, RUN);
    chk("fl.finalack", flush_ack_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
